// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO register pair with iterative signed/unsigned multiply/divide engine (optional MADD/MSUB via HILO_MADD_EN)
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;       // {partial hi / remainder, multiplier / quotient}
    logic               neg_q, neg_d;       // product or quotient must be negated
    logic               rneg_q, rneg_d;     // remainder must be negated (dividend sign)
    logic               dz_q, dz_d;         // divide by zero: quotient forced to all ones
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Only MULTU and DIVU treat operands as unsigned
    logic             op_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // Magnitude extraction of the incoming operands
    always_comb begin
        op_signed = ~(Op[0] & ~Op[2]);
        a_neg     = op_signed & A[WIDTH-1];
        b_neg     = op_signed & B[WIDTH-1];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;
    end

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Per-iteration datapath and final sign correction
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q};
        prod_fix  = neg_q ? -acc_q : acc_q;
        quo_fix   = dz_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        rem_fix   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

`ifdef HILO_MADD_EN
    logic [2*WIDTH-1:0] hilo_add;
    logic [2*WIDTH-1:0] hilo_sub;

    // Accumulate paths for MADD/MSUB, modulo 2^(2*WIDTH)
    always_comb begin
        hilo_add = {hi_q, lo_q} + prod_fix;
        hilo_sub = {hi_q, lo_q} - prod_fix;
    end
`endif

    // Next-state logic for the engine FSM and the HI/LO pair
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    case (Op)
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        OP_DIV, OP_DIVU: begin
                            op_d    = Op;
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            mcand_d = b_mag;
                            neg_d   = a_neg ^ b_neg;
                            rneg_d  = a_neg;
                            dz_d    = (B == '0);
                            cnt_d   = '0;
                            state_d = ST_DIV;
                        end
`ifdef HILO_MADD_EN
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
`else
                        OP_MULT, OP_MULTU: begin
`endif
                            op_d    = Op;
                            acc_d   = {{WIDTH{1'b0}}, b_mag};
                            mcand_d = a_mag;
                            neg_d   = a_neg ^ b_neg;
                            rneg_d  = 1'b0;
                            dz_d    = 1'b0;
                            cnt_d   = '0;
                            state_d = ST_MUL;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                // add multiplicand when the current multiplier bit is set, then shift right
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) state_d = ST_FIX;
            end
            ST_DIV: begin
                // restoring step: keep the subtraction only when it does not go negative
                if (!div_trial[WIDTH])
                    acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else
                    acc_d = {acc_q[2*WIDTH-2:WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) state_d = ST_FIX;
            end
            default: begin
                case (op_q)
                    OP_DIV, OP_DIVU: begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
`ifdef HILO_MADD_EN
                    OP_MADD: {hi_d, lo_d} = hilo_add;
                    OP_MSUB: {hi_d, lo_d} = hilo_sub;
`endif
                    default: {hi_d, lo_d} = prod_fix;
                endcase
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; Clr aborts any operation in flight
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign Busy = (state_q != ST_IDLE);
    assign Done = done_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - randomized self-checking bench for hilo_muldiv against an arithmetic reference model
module tb_hilo_muldiv;

    logic        Clk;
    logic        Clr;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;

    hilo_muldiv #(.WIDTH(32)) dut (
        .Clk   (Clk),
        .Clr   (Clr),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .Hi    (Hi),
        .Lo    (Lo),
        .Busy  (Busy),
        .Done  (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_long(input logic [2:0] op);
`ifdef HILO_MADD_EN
        return op != 3'b100 && op != 3'b101;
`else
        return op <= 3'b011;
`endif
    endfunction

    // Reference: MIPS HI/LO semantics in plain 64-bit arithmetic
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'b000: begin p = sa * sb; {mdl_hi, mdl_lo} = p; end
            3'b001: begin p = ua * ub; {mdl_hi, mdl_lo} = p; end
            3'b010, 3'b011: begin
                if (b == 32'b0) begin
                    mdl_lo = 32'hFFFF_FFFF;
                    mdl_hi = a;
                end else if (op == 3'b010) begin
                    q = sa / sb;
                    r = sa % sb;
                    mdl_lo = q[31:0];
                    mdl_hi = r[31:0];
                end else begin
                    p = ua / ub;
                    mdl_lo = p[31:0];
                    p = ua % ub;
                    mdl_hi = p[31:0];
                end
            end
            3'b100: mdl_hi = a;
            3'b101: mdl_lo = a;
`ifdef HILO_MADD_EN
            3'b110: begin p = sa * sb; {mdl_hi, mdl_lo} = {mdl_hi, mdl_lo} + p; end
            3'b111: begin p = sa * sb; {mdl_hi, mdl_lo} = {mdl_hi, mdl_lo} - p; end
`endif
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [63:0] old_hilo;
        int n;
        old_hilo = {mdl_hi, mdl_lo};
        model(op, a, b);
        Start = 1'b1; Op = op; A = a; B = b;
        @(posedge Clk); #1;
        Start = 1'b0; A = $urandom; B = $urandom;
        if (is_long(op)) begin
            check_eq("busy_at_start", 64'(Busy), 64'd1);
            check_eq("done_low_at_start", 64'(Done), 64'd0);
            check_eq("hilo_held", {Hi, Lo}, old_hilo);
            n = 0;
            while (Busy && n < 100) begin
                if (poke && n == 3) begin
                    Start = 1'b1; Op = 3'b001; A = $urandom; B = $urandom;
                end
                @(posedge Clk); #1;
                Start = 1'b0;
                n++;
            end
            check_eq("latency", 64'(n), 64'd33);
            check_eq("done_pulse", 64'(Done), 64'd1);
            check_eq("hi", 64'(Hi), 64'(mdl_hi));
            check_eq("lo", 64'(Lo), 64'(mdl_lo));
        end else begin
            check_eq("short_busy", 64'(Busy), 64'd0);
            check_eq("short_done", 64'(Done), 64'd0);
            check_eq("short_hi", 64'(Hi), 64'(mdl_hi));
            check_eq("short_lo", 64'(Lo), 64'(mdl_lo));
        end
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dones;
        Clr = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
        @(posedge Clk); @(posedge Clk); #1;
        check_eq("rst_hi", 64'(Hi), 64'd0);
        check_eq("rst_lo", 64'(Lo), 64'd0);
        check_eq("rst_busy", 64'(Busy), 64'd0);
        check_eq("rst_done", 64'(Done), 64'd0);
        Clr = 1'b0;

        run_op(3'b000, 32'hFFFF_FFFD, 32'd5, 1'b0);
        check_eq("mult_m3x5", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(3'b011, 32'd100, 32'd7, 1'b0);
        check_eq("divu_100_7", {Hi, Lo}, {32'd2, 32'd14});
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_eq("div_m7_2", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'b010, 32'h1234_5678, 32'd0, 1'b0);
        check_eq("div_by_zero", {Hi, Lo}, 64'h1234_5678_FFFF_FFFF);
        run_op(3'b011, 32'h8765_4321, 32'd0, 1'b0);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_eq("div_overflow", {Hi, Lo}, 64'h0000_0000_8000_0000);
        run_op(3'b100, 32'hAAAA_0000, 32'd0, 1'b0);
        run_op(3'b101, 32'h0000_5555, 32'd0, 1'b0);
        check_eq("mthi_mtlo", {Hi, Lo}, 64'hAAAA_0000_0000_5555);
        run_op(3'b001, 32'h0001_2345, 32'h0006_789A, 1'b1);

        // Clr in the middle of a long multiply discards it
        Start = 1'b1; Op = 3'b001; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (9) @(posedge Clk);
        #1 Clr = 1'b1;
        @(posedge Clk); #1;
        Clr = 1'b0;
        mdl_hi = '0; mdl_lo = '0;
        check_eq("abort_hilo", {Hi, Lo}, 64'd0);
        check_eq("abort_busy", 64'(Busy), 64'd0);
        dones = 0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (Done) dones++;
        end
        check_eq("abort_no_done", 64'(dones), 64'd0);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_eq("multu_max", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);

        // Accumulate ops: real MADD/MSUB when enabled, otherwise no-ops
        run_op(3'b100, 32'd0, 32'd0, 1'b0);
        run_op(3'b101, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op(3'b110, 32'd1, 32'd1, 1'b0);
`ifdef HILO_MADD_EN
        check_eq("madd_carry", {Hi, Lo}, 64'h0000_0001_0000_0000);
`else
        check_eq("madd_noop", {Hi, Lo}, 64'h0000_0000_FFFF_FFFF);
`endif
        run_op(3'b111, 32'd2, 32'd1, 1'b0);
`ifdef HILO_MADD_EN
        check_eq("msub_borrow", {Hi, Lo}, 64'h0000_0000_FFFF_FFFE);
`else
        check_eq("msub_noop", {Hi, Lo}, 64'h0000_0000_FFFF_FFFF);
`endif

        for (int i = 0; i < 60; i++) begin
            run_op(3'($urandom_range(0, 7)), rnd32(), rnd32(), ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
